// File: rtl/key_load_ctrl.sv
// key_load_ctrl: serial unlock-key loader with checksum verification, fail counting and sticky lockout
module key_load_ctrl #(
  parameter int KEY_W    = 22,
  parameter int CHK_W    = 4,
  parameter int MAX_FAIL = 3,
  parameter int TIMEOUT  = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          kbit_valid,
  input  logic                          kbit,
  output logic                          kbit_ready,
  output logic [KEY_W-1:0]              key,
  output logic                          key_valid,
  output logic                          busy,
  output logic                          fail,
  output logic                          lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);
  localparam int TOT  = KEY_W + CHK_W;
  localparam int PW   = ((KEY_W + CHK_W - 1) / CHK_W) * CHK_W;
  localparam int FW   = $clog2(MAX_FAIL + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int CW   = $clog2(TOT);
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, ARMED, LOCKED} state_t;
  state_t          state;
  logic [TOT-1:0]  sr;
  logic [CW-1:0]   cnt;
  logic [TW-1:0]   timer;
  logic [PW-1:0]   padded;
  logic [CHK_W-1:0] exp_chk;
  logic [FW-1:0]   fail_inc;
  logic            last_fail;
  // fold the zero-padded key into CHK_W-bit slices and compute the fail bookkeeping
  always_comb begin
    padded  = PW'(sr[TOT-1:CHK_W]);
    exp_chk = '0;
    for (int i = 0; i < PW / CHK_W; i++) exp_chk = exp_chk ^ padded[i*CHK_W +: CHK_W];
    fail_inc  = (fail_cnt == FW'(MAX_FAIL)) ? fail_cnt : fail_cnt + 1'b1;
    last_fail = (fail_inc == FW'(MAX_FAIL));
  end
  // load sequencer; outputs are registered alongside each state transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      timer      <= '0;
      key        <= '0;
      key_valid  <= 1'b0;
      busy       <= 1'b0;
      kbit_ready <= 1'b0;
      fail       <= 1'b0;
      lockout    <= 1'b0;
      fail_cnt   <= '0;
    end else begin
      fail <= 1'b0;
      case (state)
        IDLE, ARMED: if (start) begin
          state      <= LOAD;
          key        <= '0;
          key_valid  <= 1'b0;
          cnt        <= '0;
          timer      <= '0;
          kbit_ready <= 1'b1;
          busy       <= 1'b1;
        end
        LOAD: if (abort) begin
          state      <= IDLE;
          kbit_ready <= 1'b0;
          busy       <= 1'b0;
        end else if (kbit_valid && kbit_ready) begin
          sr    <= {sr[TOT-2:0], kbit};
          timer <= '0;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(TOT - 1)) begin
            state      <= CHECK;
            kbit_ready <= 1'b0;
          end
        end else if (timer == TW'(TIMEOUT - 1)) begin
          state      <= last_fail ? LOCKED : IDLE;
          lockout    <= last_fail;
          fail       <= 1'b1;
          fail_cnt   <= fail_inc;
          kbit_ready <= 1'b0;
          busy       <= 1'b0;
        end else begin
          timer <= timer + 1'b1;
        end
        CHECK: begin
          busy <= 1'b0;
          if (exp_chk == sr[CHK_W-1:0]) begin
            state     <= ARMED;
            key       <= sr[TOT-1:CHK_W];
            key_valid <= 1'b1;
            fail_cnt  <= '0;
          end else begin
            state    <= last_fail ? LOCKED : IDLE;
            lockout  <= last_fail;
            fail     <= 1'b1;
            fail_cnt <= fail_inc;
          end
        end
        default: begin
          key        <= '0;
          key_valid  <= 1'b0;
          kbit_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_key_load_ctrl.sv
// tb_key_load_ctrl: scoreboard-driven checks of key loading, checksum, timeout, abort and lockout
module tb_key_load_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        kbit_valid = 1'b0;
  logic        kbit = 1'b0;
  logic        kbit_ready;
  logic [21:0] key;
  logic        key_valid;
  logic        busy;
  logic        fail;
  logic        lockout;
  logic [1:0]  fail_cnt;
  typedef struct {
    logic        ok;
    logic [21:0] key;
  } exp_t;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  logic [1:0] exp_fc = 2'd0;

  key_load_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .kbit_valid(kbit_valid), .kbit(kbit), .kbit_ready(kbit_ready),
    .key(key), .key_valid(key_valid), .busy(busy), .fail(fail),
    .lockout(lockout), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bits(input logic [25:0] bits, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      kbit_valid = 1'b1;
      kbit = bits[25-i];
      @(negedge clk);
      if (gap != 0) begin
        kbit_valid = 1'b0;
        @(negedge clk);
      end
    end
    kbit_valid = 1'b0;
  endtask

  task automatic wait_result(input string name);
    exp_t e;
    int n = 0;
    while (!key_valid && !fail && n < 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else if (!key_valid && !fail) begin
      void'(sb.pop_front());
      errors++;
      $display("FAIL %s: no outcome within 8 cycles", name);
    end else begin
      e = sb.pop_front();
      exp_fc = e.ok ? 2'd0 : (exp_fc == 2'd3 ? 2'd3 : exp_fc + 2'd1);
      checks++;
      if (key_valid !== e.ok) begin errors++; $display("FAIL %s key_valid: got %b want %b", name, key_valid, e.ok); end
      checks++;
      if (key !== (e.ok ? e.key : 22'h0)) begin errors++; $display("FAIL %s key: got %h want %h", name, key, e.ok ? e.key : 22'h0); end
      checks++;
      if (fail !== !e.ok) begin errors++; $display("FAIL %s fail: got %b want %b", name, fail, !e.ok); end
      checks++;
      if (fail_cnt !== exp_fc) begin errors++; $display("FAIL %s fail_cnt: got %0d want %0d", name, fail_cnt, exp_fc); end
      checks++;
      if (lockout !== (exp_fc == 2'd3)) begin errors++; $display("FAIL %s lockout: got %b want %b", name, lockout, exp_fc == 2'd3); end
    end
  endtask

  task automatic do_load(input logic [21:0] k, input logic [3:0] c, input int gap, input logic ok, input string name);
    pulse_start();
    checks++;
    if (kbit_ready !== 1'b1 || key_valid !== 1'b0 || key !== 22'h0) begin
      errors++;
      $display("FAIL %s load entry: ready=%b key_valid=%b key=%h want 1 0 0", name, kbit_ready, key_valid, key);
    end
    sb.push_back('{ok, k});
    send_bits({k, c}, 26, gap);
    wait_result(name);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({key, key_valid, busy, kbit_ready, fail, lockout, fail_cnt} !== 29'h0) begin
      errors++;
      $display("FAIL reset_hold: got outputs %h want 0", {key, key_valid, busy, kbit_ready, fail, lockout, fail_cnt});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    pulse_start();
    send_bits({22'h3FFFFF, 4'hC}, 10, 0);
    checks++;
    if (busy !== 1'b1 || kbit_ready !== 1'b1) begin errors++; $display("FAIL mid_reset busy: got busy=%b ready=%b want 1 1", busy, kbit_ready); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({key, key_valid, busy, kbit_ready, fail, lockout, fail_cnt} !== 29'h0) begin
      errors++;
      $display("FAIL mid_reset async: got outputs %h want 0", {key, key_valid, busy, kbit_ready, fail, lockout, fail_cnt});
    end
    @(negedge clk);
    rst = 1'b0;
    exp_fc = 2'd0;
    @(negedge clk);
    do_load(22'h3FFFFF, 4'hC, 0, 1'b1, "after_reset_load");
  endtask

  task automatic test_basic_load();
    pulse_start();
    sb.push_back('{1'b1, 22'h000001});
    send_bits({22'h000001, 4'h1}, 26, 0);
    checks++;
    if (busy !== 1'b1 || kbit_ready !== 1'b0 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_check_state: got busy=%b ready=%b key_valid=%b want 1 0 0", busy, kbit_ready, key_valid);
    end
    @(negedge clk);
    checks++;
    if (key_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got key_valid=%b want 1 at edge k+1", key_valid); end
    wait_result("basic_load");
  endtask

  task automatic test_toggle_and_bad();
    do_load(22'h3FFFFF, 4'hC, 1, 1'b1, "toggle_valid_load");
    do_load(22'h3FFFFF, 4'hF, 0, 1'b0, "bad_checksum");
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || kbit_ready !== 1'b0 || fail !== 1'b0 || key !== 22'h0) begin
      errors++;
      $display("FAIL bad_checksum_idle: got busy=%b ready=%b fail=%b key=%h want 0 0 0 0", busy, kbit_ready, fail, key);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    pulse_start();
    send_bits({22'h000001, 4'h1}, 5, 0);
    while (!fail && n < 400) begin
      @(negedge clk);
      n++;
    end
    exp_fc = exp_fc + 2'd1;
    checks++;
    if (n !== 255) begin errors++; $display("FAIL timeout_cycles: got %0d want 255", n); end
    checks++;
    if (fail_cnt !== exp_fc || busy !== 1'b0) begin errors++; $display("FAIL timeout_state: got fail_cnt=%0d busy=%b want %0d 0", fail_cnt, busy, exp_fc); end
  endtask

  task automatic test_abort();
    pulse_start();
    send_bits({22'h000001, 4'h1}, 5, 0);
    abort = 1'b1;
    kbit_valid = 1'b1;
    kbit = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    kbit_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || kbit_ready !== 1'b0 || fail !== 1'b0 || fail_cnt !== exp_fc) begin
      errors++;
      $display("FAIL abort: got busy=%b ready=%b fail=%b fail_cnt=%0d want 0 0 0 %0d", busy, kbit_ready, fail, fail_cnt, exp_fc);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (fail !== 1'b0 || key_valid !== 1'b0) begin errors++; $display("FAIL abort_quiet: got fail=%b key_valid=%b want 0 0", fail, key_valid); end
  endtask

  task automatic test_reload();
    do_load(22'h2AAAAA, 4'h8, 0, 1'b1, "armed_load");
    pulse_start();
    checks++;
    if (key !== 22'h0 || key_valid !== 1'b0) begin errors++; $display("FAIL reload_drop: got key=%h key_valid=%b want 0 0", key, key_valid); end
    sb.push_back('{1'b1, 22'h000001});
    for (int i = 0; i < 26; i++) begin
      kbit_valid = 1'b1;
      kbit = i < 25 ? 1'b0 : 1'b1;
      if (i == 21) kbit = 1'b1;
      @(negedge clk);
      if (key !== 22'h0 || key_valid !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL reload_partial: got key=%h key_valid=%b want 0 0 during load", key, key_valid);
      end
    end
    kbit_valid = 1'b0;
    wait_result("reload");
  endtask

  task automatic test_lockout();
    do_load(22'h123456, 4'h0, 0, 1'b0, "lock_bad1");
    do_load(22'h123456, 4'h0, 0, 1'b0, "lock_bad2");
    do_load(22'h123456, 4'h0, 0, 1'b0, "lock_bad3");
    pulse_start();
    checks++;
    if (kbit_ready !== 1'b0 || busy !== 1'b0 || lockout !== 1'b1) begin
      errors++;
      $display("FAIL lockout_start: got ready=%b busy=%b lockout=%b want 0 0 1", kbit_ready, busy, lockout);
    end
    send_bits({22'h000001, 4'h1}, 26, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (key_valid !== 1'b0 || key !== 22'h0 || lockout !== 1'b1 || fail_cnt !== 2'd3) begin
      errors++;
      $display("FAIL lockout_hold: got key_valid=%b key=%h lockout=%b fail_cnt=%0d want 0 0 1 3", key_valid, key, lockout, fail_cnt);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mid_reset();
    test_basic_load();
    test_toggle_and_bad();
    test_timeout();
    test_abort();
    test_reload();
    test_lockout();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
